// File: rtl/fbuf_arb_pkg.sv
// Shared FSM state encoding and framebuffer geometry for the framebuffer write arbiter.
package fbuf_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_GNT0  = 2'd1;
    localparam arb_state_t ST_GNT1  = 2'd2;
    localparam arb_state_t ST_FLUSH = 2'd3;

    localparam int FBUF_DEPTH_DEFAULT = 230400;

endpackage

// File: rtl/fbuf_arb_stats.sv
// Saturating per-requester counts of issued framebuffer writes (FBUF_ARB_STATS_EN builds only).
// Counts the registered write strobe; clear wins over a same-cycle write.
module fbuf_arb_stats
    import fbuf_arb_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_we,
    input  logic        i_src,
    output logic [31:0] o_beats0,
    output logic [31:0] o_beats1
);

    logic [31:0] beats0_q, beats0_d;
    logic [31:0] beats1_q, beats1_d;

    always_comb begin
        beats0_d = beats0_q;
        beats1_d = beats1_q;
        if (i_clr) begin
            beats0_d = '0;
            beats1_d = '0;
        end else if (i_we) begin
            if (!i_src && beats0_q != '1) beats0_d = beats0_q + 32'd1;
            if (i_src && beats1_q != '1)  beats1_d = beats1_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            beats0_q <= '0;
            beats1_q <= '0;
        end else begin
            beats0_q <= beats0_d;
            beats1_q <= beats1_d;
        end
    end

    assign o_beats0 = beats0_q;
    assign o_beats1 = beats1_q;

endmodule

// File: rtl/fbuf_wr_arbiter.sv
// Two-requester framebuffer write arbiter: bounded bursts, round-robin, flush, range check; write 1 cycle after accept.
// Requesters stall on low grant; FBUF_ARB_STATS_EN adds o_beats0/o_beats1 write counters.
module fbuf_wr_arbiter
    import fbuf_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 18,
    parameter int FBUF_DEPTH = FBUF_DEPTH_DEFAULT,
    parameter int MAX_BURST  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    input  logic                  i_flush,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata,
`ifdef FBUF_ARB_STATS_EN
    output logic [31:0]           o_beats0,
    output logic [31:0]           o_beats1,
`endif
    output logic                  o_err
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  prio1_q, prio1_d;
    logic                  gap_q, gap_d;
    logic                  gnt0_q, gnt0_d;
    logic                  gnt1_q, gnt1_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  acc0, acc1, acc, in_range, last_beat;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    assign acc0      = i_req0 && gnt0_q;
    assign acc1      = i_req1 && gnt1_q;
    assign acc       = acc0 || acc1;
    assign sel_addr  = acc1 ? i_addr1 : i_addr0;
    assign sel_data  = acc1 ? i_data1 : i_data0;
    assign in_range  = 32'(sel_addr) < 32'(FBUF_DEPTH);
    assign last_beat = acc && (cnt_q == CNT_W'(MAX_BURST - 1));

    // A max-length burst with nobody else waiting re-enters the same grant
    // state but drops the grant for one cycle (gap) to bound each grant.
    always_comb begin
        state_d = state_q;
        cnt_d   = acc ? cnt_q + CNT_W'(1) : cnt_q;
        prio1_d = prio1_q;
        gap_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req0 && !(i_req1 && prio1_q)) begin
                    state_d = ST_GNT0;
                    cnt_d   = '0;
                end else if (i_req1) begin
                    state_d = ST_GNT1;
                    cnt_d   = '0;
                end
            end
            ST_GNT0: begin
                if (last_beat || !i_req0) begin
                    prio1_d = 1'b1;
                    cnt_d   = '0;
                    if (i_req1)      state_d = ST_GNT1;
                    else if (i_req0) gap_d   = 1'b1;
                    else             state_d = ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (last_beat || !i_req1) begin
                    prio1_d = 1'b0;
                    cnt_d   = '0;
                    if (i_req0)      state_d = ST_GNT0;
                    else if (i_req1) gap_d   = 1'b1;
                    else             state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d = '0;
                if (!i_flush) begin
                    state_d = ST_IDLE;
                    prio1_d = 1'b0;
                end
            end
        endcase
        if (i_flush) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
            gap_d   = 1'b0;
        end
    end

    // A beat accepted in the same cycle as a flush request is dropped.
    always_comb begin
        we_d    = acc && in_range && !i_flush;
        waddr_d = we_d ? sel_addr : waddr_q;
        wdata_d = we_d ? sel_data : wdata_q;
        err_d   = err_q || (acc && !in_range);
        gnt0_d  = (state_d == ST_GNT0) && !gap_d;
        gnt1_d  = (state_d == ST_GNT1) && !gap_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prio1_q <= 1'b0;
            gap_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio1_q <= prio1_d;
            gap_q   <= gap_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            we_q    <= we_d;
            err_q   <= err_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_gnt0  = gnt0_q;
    assign o_gnt1  = gnt1_q;
    assign o_we    = we_q;
    assign o_waddr = waddr_q;
    assign o_wdata = wdata_q;
    assign o_err   = err_q;

`ifdef FBUF_ARB_STATS_EN
    logic src_q, src_d;

    assign src_d = we_d ? acc1 : src_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) src_q <= 1'b0;
        else       src_q <= src_d;
    end

    fbuf_arb_stats u_stats (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (i_flush && (state_q != ST_FLUSH)),
        .i_we     (we_q),
        .i_src    (src_q),
        .o_beats0 (o_beats0),
        .o_beats1 (o_beats1)
    );
`endif

endmodule

// File: doc/fbuf_wr_arbiter.md
FBUF_WR_ARBITER -- requirements
Module: fbuf_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, pixel word width.
REQ-002 Parameter ADDR_WIDTH, default 18, framebuffer address width.
REQ-003 Parameter FBUF_DEPTH, default 230400, number of valid framebuffer words.
REQ-004 Parameter MAX_BURST, default 16, maximum beats per grant, range 1..256.
REQ-005 Port i_clk  input  1  sole clock, 125 MHz system clock.
REQ-006 Port i_rst  input  1  reset, asynchronous, active-high.
REQ-007 Ports i_req0/i_req1  input  1  requester 0 (pixel stream) and requester 1 (overlay writer) request.
REQ-008 Ports i_addr0/i_addr1  input  ADDR_WIDTH  write address per requester.
REQ-009 Ports i_data0/i_data1  input  DATA_WIDTH  write data per requester.
REQ-010 Ports o_gnt0/o_gnt1  output  1  registered grant per requester.
REQ-011 Port i_flush  input  1  pipeline flush, level-sensitive.
REQ-012 Ports o_we  output  1, o_waddr  output  ADDR_WIDTH, o_wdata  output  DATA_WIDTH: framebuffer write port.
REQ-013 Port o_err  output  1  sticky out-of-range address flag.

Function
REQ-014 Beat on requester N accepted in any cycle with i_reqN && o_gntN; requester holds addr/data stable while req high and gnt low.
REQ-015 Accepted beat appears on o_we/o_waddr/o_wdata exactly one cycle later; o_we low otherwise.
REQ-016 FSM states IDLE, GNT0, GNT1, FLUSH; o_gnt0 high only in GNT0, o_gnt1 only in GNT1; at most one grant high.
REQ-017 IDLE: single requester -> its GNT state next cycle; both requesting -> requester not served last (pointer), pointer reset value favours 0; none -> stay IDLE.
REQ-018 Burst counter cleared on grant entry, incremented per accepted beat.
REQ-019 Burst ends on accepted beat with counter == MAX_BURST-1, or cycle in GNTN with i_reqN low.
REQ-020 Burst end: other requester requesting -> its GNT state next cycle; else if own req still high (max-burst end) -> re-enter own GNT with counter cleared; else IDLE; pointer updated to ended requester.
REQ-021 Beat with address >= FBUF_DEPTH: accepted (gnt honoured) but o_we stays low; o_err set and held until reset.
REQ-022 i_flush high in any state -> FLUSH next cycle; overrides every other transition including simultaneous burst end.
REQ-023 FLUSH: both grants low, o_we low from the cycle after entry, in-flight registered beat discarded, burst counter cleared.
REQ-024 FLUSH -> IDLE on first cycle i_flush low; pointer reset to favour requester 0.

Reset
REQ-025 On i_rst: state IDLE, o_gnt0=o_gnt1=0, o_we=0, o_waddr=0, o_wdata=0, o_err=0, counter=0, pointer favours 0.
REQ-026 Reset mid-burst discards pending beat; no write issued after reset deassertion until new grant.

Configuration
REQ-027 Macro FBUF_ARB_STATS_EN defined: extra outputs o_beats0/o_beats1 (32-bit each) count o_we-issued writes per requester, saturating at all-ones, cleared on reset and on FLUSH entry.
REQ-028 Macro undefined: stats ports and counters absent; all other behaviour identical.

Structure
REQ-029 Shared package fbuf_arb_pkg holds the FSM state typedef and the FBUF_DEPTH default constant.
REQ-030 Optional sub-module fbuf_arb_stats contains the saturating counters, instantiated only under FBUF_ARB_STATS_EN.

Verification
REQ-031 req0 held 40 beats, req1 idle, MAX_BURST=16 -> 40 consecutive writes; 1-cycle grant gaps at beats 16 and 32; o_gnt1 never high.
REQ-032 req0 and req1 both high from reset -> GNT0 first; 16 beats each alternately; o_waddr sequence matches source order.
REQ-033 i_flush pulsed 3 cycles mid-GNT1 burst at beat 5 -> grants low, no o_we after flush+1; after flush, req0 and req1 pending -> GNT0 first.
REQ-034 req1 beat with addr 230400 -> no o_we that cycle+1, o_err=1 and stays 1; following beat addr 0 written normally.
REQ-035 i_rst asserted mid-GNT0 burst -> all outputs 0 asynchronously; after release, first o_we only after new grant.
REQ-036 FBUF_ARB_STATS_EN build: 20 req0 beats and 7 req1 beats -> o_beats0=20, o_beats1=7; flush -> both 0.
